// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: state encoding and index helpers.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // The top index of the address space is reserved for the PC read-through.
    function automatic int pc_idx(int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic int n_entries(int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read bus between the datapath and regfile_mp; master drives indices and data.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic                       WE3;
    logic [ADDR_W-1:0]          A3;
    logic [DATA_W-1:0]          WD3;
    logic [DATA_W-1:0]          R15;
    logic [NUM_RD*ADDR_W-1:0]   A;
    logic [NUM_RD*DATA_W-1:0]   RD;
    logic                       BUSY;

    modport master (output WE3, A3, WD3, R15, A, input RD, BUSY);
    modport slave  (input WE3, A3, WD3, R15, A, output RD, BUSY);
endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks ptr over every storage entry after reset, one per edge.
// BUSY is decoded straight from the state register; no backpressure, writes are simply locked out.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(n_entries(ADDR_W) - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;

    // ptr parks on LAST once RUN is reached, so it never wraps onto the PC index.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else if (state_q == CLEAR) begin
            if (ptr_q == LAST) begin
                state_q <= RUN;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    assign busy_o    = (state_q == CLEAR);
    assign clr_we_o  = rst_n_i && (state_q == CLEAR);
    assign clr_idx_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with PC read-through, sequenced clear and optional write bypass.
// Reads are zero-latency; writes land on the rising edge and are dropped while BUSY or in reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input logic         CLK,
    input logic         RESETn,
    regfile_mp_if.slave bus
);
    localparam int                NENT = n_entries(ADDR_W);
    localparam logic [ADDR_W-1:0] PC   = ADDR_W'(pc_idx(ADDR_W));

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_dat;

    logic [DATA_W-1:0] mem_q [NENT];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i     (CLK),
        .rst_n_i   (RESETn),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    // The clear sequence owns the write port while it runs; user writes to the PC index vanish.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = clr_idx;
        wr_dat = '0;
        if (RESETn) begin
            if (clr_we) begin
                wr_en = 1'b1;
            end else if (bus.WE3 && (bus.A3 != PC)) begin
                wr_en  = 1'b1;
                wr_idx = bus.A3;
                wr_dat = bus.WD3;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_idx;
        logic [DATA_W-1:0] rd_dat;

        assign rd_idx = bus.A[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd_dat = mem_q[rd_idx];
            if (rd_idx == PC) begin
                rd_dat = bus.R15;
            end else if (busy) begin
                rd_dat = '0;
            end else if ((BYPASS != 0) && bus.WE3 && (bus.A3 == rd_idx)) begin
                rd_dat = bus.WD3;
            end
        end

        assign bus.RD[i*DATA_W +: DATA_W] = rd_dat;
    end

    assign bus.BUSY = busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the processor's 15+1 register file.
- Storage depth, data width and read-port count are configurable; the top index is still the PC read-through.
- Adds a synchronous active-low reset, a sequenced hardware clear of all storage, a BUSY flag and optional same-cycle write-to-read bypass.
- Sits in the datapath between decode (read addresses) and writeback (A3/WD3/WE3); the PC value enters on R15.

Parameters:
DATA_W, 32, width of every register and data port
ADDR_W, 4, index width; storage holds 2**ADDR_W-1 entries; index 2**ADDR_W-1 is the PC index
NUM_RD, 2, number of independent combinational read ports (1..4)
BYPASS, 1, 1 = a read of the index being written this cycle returns WD3; 0 = returns the stored (old) value

Ports:
CLK  in  1  clock; all state changes on rising edge
RESETn  in  1  synchronous reset, active-low
WE3  in  1  write enable, high active
A3  in  ADDR_W  write index
WD3  in  DATA_W  write data
R15  in  DATA_W  PC value, returned for any read of the PC index
A  in  NUM_RD*ADDR_W  read indices; port i uses A[i*ADDR_W +: ADDR_W]
RD  out  NUM_RD*DATA_W  read data; port i drives RD[i*DATA_W +: DATA_W]
BUSY  out  1  high while the clear sequence is running; writes are ignored

Behaviour:
- Reset and state machine:
  - States are CLEAR and RUN.
  - Sampled RESETn=0: next state CLEAR, clear pointer ptr<=0, BUSY=1.
  - Storage is not modified on reset cycles themselves.
- CLEAR state (RESETn=1):
  - Each edge writes 0 to entry ptr and increments ptr.
  - When ptr==2**ADDR_W-2 is written, go to RUN.
  - Sequence length is 2**ADDR_W-1 edges after reset release (15 for defaults). BUSY is 1 throughout and drops on the edge that writes the last entry.
- Reset mid-clear restarts the sequence at ptr=0.
- WE3 during CLEAR or during reset has no effect and is not queued.
- RUN state:
  - WE3=1 and A3 != PC index: entry A3 <= WD3 at the rising edge.
  - WE3=1 and A3 == PC index: silently discarded; no storage exists and R15 is unaffected.
- Reads are combinational (zero latency) and evaluated independently per port i:
  - Ai == PC index -> R15, in any state including reset.
  - else BUSY=1 -> 0.
  - else BYPASS=1, WE3=1, A3==Ai -> WD3.
  - else stored entry Ai.
- Multiple ports may read the same index simultaneously; all return the identical value.
- Output reset values: BUSY=1; every RD port returns 0 unless addressing the PC index (R15).
- No arithmetic; pointer is ADDR_W bits and never wraps past 2**ADDR_W-2.
- Out-of-range NUM_RD is an elaboration error.

Decomposition:
- Shared package regfile_pkg holds:
  - state encoding: CLEAR=1'b0, RUN=1'b1
  - PC-index function pc_idx(ADDR_W) = 2**ADDR_W-1
  - entry-count function n_entries(ADDR_W)
- One natural sub-module, regfile_clear_seq. It owns the state register, ptr and BUSY, and outputs a clear-write enable and index. The top level muxes these against WE3/A3/WD3.
- The read-port logic stays in the top as a generate loop over NUM_RD.

Test Plan:
1. Hold RESETn=0 for 3 cycles, then release:
   - BUSY=1 for exactly 15 edges after release, then 0.
   - Reads of 0..14 during and after return 0; read of 15 returns R15=0x0000_1000 throughout.
2. After clear, write 0xDEAD_BEEF to index 3, then read A0=3, A1=3 next cycle:
   - Both ports give 0xDEAD_BEEF.
   - With A0=4 the port gives 0.
3. BYPASS=1, index 5 holds 0x1111_1111; same cycle WE3=1, A3=5, WD3=0x2222_2222, A0=5:
   - RD0=0x2222_2222 combinationally.
   - Rebuilt with BYPASS=0: RD0=0x1111_1111 that cycle, 0x2222_2222 next.
4. WE3=1, A3=15, WD3=0xFFFF_FFFF, with R15=0x0000_0040:
   - Read of 15 gives 0x0000_0040.
   - Entries 0..14 are unchanged.
5. Write 0xA5A5_A5A5 to all entries. Pulse RESETn=0 for 1 cycle 6 edges into a new clear, and assert WE3 (A3=2, WD3=7) while BUSY:
   - Clear restarts and BUSY lasts 15 edges after release.
   - Index 2 reads 0 afterwards.
6. ADDR_W=3, NUM_RD=3:
   - Clear lasts 7 edges.
   - Index 7 returns R15.
   - Three ports reading 0, 6, 7 after writes of 1 and 6 to indices 0 and 6 return 1, 6 and R15.
